// File: rtl/ctrl_unit_mc.sv
// RV32 ID-stage sequencing control unit: opcode decode, bubble gating,
// multi-cycle MUL/DIV stall sequencer and halt drain to a sticky halted flag.
module ctrl_unit_mc #(
  parameter int MULDIV_LAT   = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int ENABLE_M     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic       id_valid,
  input  logic       flush,
  output logic       ALU_src,
  output logic [1:0] wb_data_src,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] ALU_op,
  output logic [1:0] ctrl_transfer,
  output logic       muldiv,
  output logic       stall,
  output logic       halt,
  output logic       halted
);
  localparam int MAXC = (MULDIV_LAT > DRAIN_CYCLES) ? MULDIV_LAT : DRAIN_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MD_LOAD = CW'((MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0);
  localparam logic [CW-1:0] DR_LOAD = CW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] S_RUN = 2'd0, S_MULDIV = 2'd1, S_DRAIN = 2'd2, S_HALTED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       d_alu_src, d_rw, d_mr, d_mw, d_md, is_halt;
  logic [1:0] d_wb, d_aop, d_ct;

  always_comb begin
    d_alu_src = 1'b0; d_wb = 2'b00; d_rw = 1'b0; d_mr = 1'b0; d_mw = 1'b0;
    d_aop = 2'b00; d_ct = 2'b00; d_md = 1'b0; is_halt = 1'b0;
    case (opcode)
      7'b0000011: begin d_alu_src = 1'b1; d_wb = 2'b01; d_rw = 1'b1; d_mr = 1'b1; end
      7'b0100011: begin d_alu_src = 1'b1; d_mw = 1'b1; end
      7'b0110011: begin
        d_rw = 1'b1; d_aop = 2'b01;
        d_md = (ENABLE_M != 0) && (funct7 == 7'b0000001);
      end
      7'b0010011: begin d_alu_src = 1'b1; d_rw = 1'b1; d_aop = 2'b01; end
      7'b0110111: begin d_alu_src = 1'b1; d_wb = 2'b11; d_rw = 1'b1; end
      7'b1100011: begin d_aop = 2'b10; d_ct = 2'b01; end
      7'b1101111: begin d_wb = 2'b10; d_rw = 1'b1; d_ct = 2'b10; end
      7'b1100111: begin d_alu_src = 1'b1; d_wb = 2'b10; d_rw = 1'b1; d_ct = 2'b11; end
      7'b1111111: is_halt = 1'b1;
      default: ;
    endcase
  end

  logic stall_c, halt_c, halted_c, issue_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    halt_c  = 1'b0;
    issue_c = 1'b0;
    case (state_q)
      S_RUN: if (!flush && id_valid) begin
        if (is_halt) begin
          halt_c = 1'b1; stall_c = 1'b1; cnt_d = DR_LOAD; state_d = S_DRAIN;
        end else if (d_md && MULDIV_LAT > 1) begin
          stall_c = 1'b1; cnt_d = MD_LOAD; state_d = S_MULDIV;
        end else begin
          issue_c = 1'b1;
        end
      end
      // flush aborts the sequence outright, even in its final cycle
      S_MULDIV: if (flush) begin
        state_d = S_RUN; cnt_d = '0;
      end else if (cnt_q != '0) begin
        stall_c = 1'b1; cnt_d = cnt_q - CW'(1);
      end else begin
        state_d = S_RUN; issue_c = id_valid;
      end
      S_DRAIN: begin
        stall_c = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = S_HALTED;
      end
      S_HALTED: stall_c = 1'b1;
      default: state_d = S_RUN;
    endcase
    // halted rises in the last drain cycle so it lags HALT by DRAIN_CYCLES
    halted_c = (state_q == S_HALTED) || (state_q == S_DRAIN && cnt_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic en;
  assign en            = issue_c && !reset;
  assign ALU_src       = en & d_alu_src;
  assign wb_data_src   = en ? d_wb  : 2'b00;
  assign reg_write     = en & d_rw;
  assign mem_read      = en & d_mr;
  assign mem_write     = en & d_mw;
  assign ALU_op        = en ? d_aop : 2'b00;
  assign ctrl_transfer = en ? d_ct  : 2'b00;
  assign muldiv        = en & d_md;
  assign stall         = stall_c  & !reset;
  assign halt          = halt_c   & !reset;
  assign halted        = halted_c & !reset;
endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Scoreboard bench for ctrl_unit_mc: default build plus MULDIV_LAT=1 and
// ENABLE_M=0 builds, all sharing the same stimulus.
module tb_ctrl_unit_mc;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'h03, funct7 = 7'h00;
  logic       id_valid = 1'b1, flush = 1'b0;

  logic [2:0]      alu_src_w, rw_w, mr_w, mw_w, md_w, st_w, h_w, hd_w;
  logic [2:0][1:0] wb_w, aop_w, ct_w;

  always #5 clk = ~clk;

  ctrl_unit_mc u_def (
    .clk(clk), .reset(reset), .opcode(opcode), .funct7(funct7), .id_valid(id_valid), .flush(flush),
    .ALU_src(alu_src_w[0]), .wb_data_src(wb_w[0]), .reg_write(rw_w[0]), .mem_read(mr_w[0]),
    .mem_write(mw_w[0]), .ALU_op(aop_w[0]), .ctrl_transfer(ct_w[0]), .muldiv(md_w[0]),
    .stall(st_w[0]), .halt(h_w[0]), .halted(hd_w[0]));

  ctrl_unit_mc #(.MULDIV_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct7(funct7), .id_valid(id_valid), .flush(flush),
    .ALU_src(alu_src_w[1]), .wb_data_src(wb_w[1]), .reg_write(rw_w[1]), .mem_read(mr_w[1]),
    .mem_write(mw_w[1]), .ALU_op(aop_w[1]), .ctrl_transfer(ct_w[1]), .muldiv(md_w[1]),
    .stall(st_w[1]), .halt(h_w[1]), .halted(hd_w[1]));

  ctrl_unit_mc #(.ENABLE_M(0)) u_nom (
    .clk(clk), .reset(reset), .opcode(opcode), .funct7(funct7), .id_valid(id_valid), .flush(flush),
    .ALU_src(alu_src_w[2]), .wb_data_src(wb_w[2]), .reg_write(rw_w[2]), .mem_read(mr_w[2]),
    .mem_write(mw_w[2]), .ALU_op(aop_w[2]), .ctrl_transfer(ct_w[2]), .muldiv(md_w[2]),
    .stall(st_w[2]), .halt(h_w[2]), .halted(hd_w[2]));

  typedef struct {
    int          sel;
    logic [13:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // {ALU_src, wb, reg_write, mem_read, mem_write, ALU_op, ctrl_transfer, muldiv, stall, halt, halted}
  function automatic logic [13:0] ctl(input logic a, input logic [1:0] wb, input logic rw, mr, mw,
                                      input logic [1:0] aop, ct, input logic md, st, h, hd);
    return {a, wb, rw, mr, mw, aop, ct, md, st, h, hd};
  endfunction

  function automatic logic [13:0] outv(input int s);
    return {alu_src_w[s], wb_w[s], rw_w[s], mr_w[s], mw_w[s], aop_w[s], ct_w[s],
            md_w[s], st_w[s], h_w[s], hd_w[s]};
  endfunction

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OP = 7'b0110011,
                         OPI = 7'b0010011, LUI = 7'b0110111, BR = 7'b1100011,
                         JAL = 7'b1101111, JALR = 7'b1100111, HALT = 7'b1111111;

  logic [13:0] E_LOAD, E_OP, E_MD, E_STALL, Z;

  task automatic drv(input logic [6:0] op, input logic [6:0] f7, input logic v, input logic fl,
                     input logic rs);
    opcode = op; funct7 = f7; id_valid = v; flush = fl; reset = rs;
  endtask

  task automatic expect_o(input int s, input logic [13:0] e, input string nm);
    exp_t x;
    x.sel = s; x.exp = e; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: every mid-cycle sample retires all expectations queued for this cycle
  initial begin
    exp_t e;
    logic [13:0] got;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = outv(e.sel);
        n_chk++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s (dut %0d): got %b expected %b", e.nm, e.sel, got, e.exp);
        end
      end
    end
  end

  initial begin
    E_LOAD  = ctl(1, 2'b01, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    E_OP    = ctl(0, 2'b00, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    E_MD    = ctl(0, 2'b00, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0);
    E_STALL = ctl(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0);
    Z       = '0;
    tick();

    // reset held: all outputs zero
    drv(LOAD, 0, 1, 0, 1);
    expect_o(0, Z, "reset_def"); expect_o(1, Z, "reset_lat1"); expect_o(2, Z, "reset_nom");
    tick();

    // decode sweep
    drv(LOAD, 0, 1, 0, 0);  expect_o(0, E_LOAD, "dec_load"); tick();
    drv(STORE, 0, 1, 0, 0); expect_o(0, ctl(1, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0), "dec_store"); tick();
    drv(OP, 0, 1, 0, 0);    expect_o(0, E_OP, "dec_op"); tick();
    drv(OPI, 0, 1, 0, 0);   expect_o(0, ctl(1, 2'b00, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0), "dec_opimm"); tick();
    drv(LUI, 0, 1, 0, 0);   expect_o(0, ctl(1, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0), "dec_lui"); tick();
    drv(BR, 0, 1, 0, 0);    expect_o(0, ctl(0, 2'b00, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0, 0), "dec_branch"); tick();
    drv(JAL, 0, 1, 0, 0);   expect_o(0, ctl(0, 2'b10, 1, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0), "dec_jal"); tick();
    drv(JALR, 0, 1, 0, 0);  expect_o(0, ctl(1, 2'b10, 1, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0), "dec_jalr"); tick();
    drv(7'h0B, 0, 1, 0, 0); expect_o(0, Z, "dec_illegal"); tick();

    // bubble gating
    drv(LOAD, 0, 0, 0, 0); expect_o(0, Z, "bubble_invalid"); tick();
    drv(LOAD, 0, 1, 1, 0); expect_o(0, Z, "bubble_flush"); tick();

    // MULDIV held in ID for 4 cycles; LAT=1 and ENABLE_M=0 builds issue at once
    for (int c = 0; c < 4; c++) begin
      drv(OP, 7'b0000001, 1, 0, 0);
      expect_o(0, (c == 3) ? E_MD : E_STALL, $sformatf("muldiv_c%0d", c));
      expect_o(1, E_MD, $sformatf("lat1_c%0d", c));
      expect_o(2, E_OP, $sformatf("nom_c%0d", c));
      tick();
    end
    drv(LOAD, 0, 1, 0, 0); expect_o(0, E_LOAD, "muldiv_next"); tick();

    // MULDIV abort by flush in cycle 1
    drv(OP, 7'b0000001, 1, 0, 0); expect_o(0, E_STALL, "abort_c0"); expect_o(2, E_OP, "abort_nom"); tick();
    drv(OP, 7'b0000001, 1, 1, 0); expect_o(0, Z, "abort_c1"); tick();
    drv(LOAD, 0, 1, 0, 0); expect_o(0, E_LOAD, "abort_run"); tick();

    // asynchronous reset mid-MULDIV
    drv(OP, 7'b0000001, 1, 0, 0); expect_o(0, E_STALL, "rmd_c0"); tick();
    drv(OP, 7'b0000001, 1, 0, 1); expect_o(0, Z, "rmd_reset"); tick();
    drv(LOAD, 0, 1, 0, 0); expect_o(0, E_LOAD, "rmd_release"); tick();

    // HALT squashed by flush changes nothing
    drv(HALT, 0, 1, 1, 0); expect_o(0, Z, "halt_flushed"); tick();
    drv(LOAD, 0, 1, 0, 0); expect_o(0, E_LOAD, "halt_flushed_run"); tick();

    // HALT accepted, flush pulsed during drain
    drv(HALT, 0, 1, 0, 0); expect_o(0, ctl(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0), "halt_c0"); tick();
    drv(LOAD, 0, 1, 1, 0); expect_o(0, E_STALL, "halt_c1"); tick();
    drv(LOAD, 0, 1, 0, 0); expect_o(0, E_STALL, "halt_c2"); tick();
    for (int c = 3; c < 6; c++) begin
      drv(LOAD, 0, 1, 0, 0);
      expect_o(0, ctl(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 1), $sformatf("halt_c%0d", c));
      tick();
    end

    // asynchronous reset while HALTED
    drv(LOAD, 0, 1, 0, 1); expect_o(0, Z, "rh_reset"); tick();
    drv(LOAD, 0, 1, 0, 0); expect_o(0, E_LOAD, "rh_release"); tick();

    tick(); tick();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
